// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one pipelined multiplier among NUM_REQ requesters
module mult_share_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ELEMENT_WIDTH = 32,
    parameter int LATENCY       = 2,
    parameter int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*ELEMENT_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*ELEMENT_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]                 resp_valid,
    output logic [ELEMENT_WIDTH-1:0]           resp_data,
    output logic [ELEMENT_WIDTH-1:0]           mul_a,
    output logic [ELEMENT_WIDTH-1:0]           mul_b,
    output logic                               mul_t,
    input  logic [ELEMENT_WIDTH-1:0]           mul_result,
    output logic [31:0]                        issued_cnt
);

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W:0]     cand;
    logic               found;
    logic               armed;
    logic [NUM_REQ-1:0] grant;
    logic [LATENCY-1:0] tag_valid;
    logic [IDX_W-1:0]   tag_idx [LATENCY];

    // armed keeps grants off through the first cycle after reset release
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = '0;
        if (armed && en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, ptr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_REQ))
                    cand = cand - (IDX_W+1)'(NUM_REQ);
                if (!found && req_valid[cand[IDX_W-1:0]]) begin
                    found = 1'b1;
                    gidx  = cand[IDX_W-1:0];
                end
            end
            if (found)
                grant[gidx] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign mul_t     = found;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mul_a = req_a[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
                mul_b = req_b[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            armed      <= 1'b0;
            issued_cnt <= '0;
            tag_valid  <= '0;
            for (int l = 0; l < LATENCY; l++)
                tag_idx[l] <= '0;
        end else begin
            armed <= 1'b1;
            if (found) begin
                ptr        <= (gidx == IDX_W'(NUM_REQ-1)) ? '0 : gidx + IDX_W'(1);
                issued_cnt <= issued_cnt + 32'd1;
            end
            tag_valid[0] <= found;
            tag_idx[0]   <= gidx;
            for (int l = 1; l < LATENCY; l++) begin
                tag_valid[l] <= tag_valid[l-1];
                tag_idx[l]   <= tag_idx[l-1];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            resp_valid[i] = tag_valid[LATENCY-1] && (tag_idx[LATENCY-1] == IDX_W'(i));
    end

    assign resp_data = mul_result;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - randomized bench against a queue-based scoreboard model
module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [127:0] req_a, req_b;
    logic [3:0]  resp_valid;
    logic [31:0] resp_data, mul_a, mul_b, mul_result, issued_cnt;
    logic        mul_t;

    logic [1:0]  req_valid2, req_ready2, resp_valid2;
    logic [63:0] req_a2, req_b2;
    logic [31:0] resp_data2, mul_a2, mul_b2, mul_result2, issued_cnt2;
    logic        mul_t2;

    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    logic [31:0] a2, b2;
    logic [31:0] mpipe  [2];
    logic [31:0] mpipe2 [4];

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] prod;
    } resp_t;

    resp_t sb[$];
    resp_t sb2[$];
    int    m_ptr, m_cnt, m_cnt2, cyc;
    bit    m_armed;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NUM_REQ(4), .ELEMENT_WIDTH(32), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_t(mul_t),
        .mul_result(mul_result), .issued_cnt(issued_cnt)
    );

    mult_share_arbiter #(.NUM_REQ(2), .ELEMENT_WIDTH(32), .LATENCY(4)) dut2 (
        .clk(clk), .rst(rst), .en(1'b1),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_a(req_a2), .req_b(req_b2),
        .resp_valid(resp_valid2), .resp_data(resp_data2),
        .mul_a(mul_a2), .mul_b(mul_b2), .mul_t(mul_t2),
        .mul_result(mul_result2), .issued_cnt(issued_cnt2)
    );

    // external multipliers: unreset, so stale products exist after reset
    always @(posedge clk) begin
        mpipe[0] <= mul_a * mul_b;
        mpipe[1] <= mpipe[0];
        mpipe2[0] <= mul_a2 * mul_b2;
        for (int s = 1; s < 4; s++)
            mpipe2[s] <= mpipe2[s-1];
    end
    assign mul_result  = mpipe[1];
    assign mul_result2 = mpipe2[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        int          g;
        logic [3:0]  exp_rv;
        logic [1:0]  exp_rv2;
        req_a      = {op_a[3], op_a[2], op_a[1], op_a[0]};
        req_b      = {op_b[3], op_b[2], op_b[1], op_b[0]};
        req_a2     = {32'hdead_beef, a2};
        req_b2     = {32'h1234_5678, b2};
        req_valid2 = 2'b01;
        @(negedge clk);
        if (!rst) begin
            sb.delete();
            sb2.delete();
            m_ptr   = 0;
            m_cnt   = 0;
            m_cnt2  = 0;
            m_armed = 0;
        end
        g = -1;
        if (rst && m_armed && en)
            for (int k = 0; k < 4; k++)
                if (g < 0 && req_valid[(m_ptr + k) % 4])
                    g = (m_ptr + k) % 4;
        check_eq("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        check_eq("mul_t", 32'(mul_t), (g >= 0) ? 32'd1 : 32'd0);
        check_eq("mul_a", mul_a, (g >= 0) ? op_a[g] : 32'd0);
        check_eq("mul_b", mul_b, (g >= 0) ? op_b[g] : 32'd0);
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_rv = 4'(1 << sb[0].idx);
            check_eq("resp_data", resp_data, sb[0].prod);
            void'(sb.pop_front());
        end
        check_eq("resp_valid", 32'(resp_valid), 32'(exp_rv));
        check_eq("issued_cnt", issued_cnt, 32'(m_cnt));

        check_eq("l4_ready", 32'(req_ready2), (rst && m_armed) ? 32'd1 : 32'd0);
        exp_rv2 = '0;
        if (sb2.size() > 0 && sb2[0].due == cyc) begin
            exp_rv2 = 2'b01;
            check_eq("l4_resp_data", resp_data2, sb2[0].prod);
            void'(sb2.pop_front());
        end
        check_eq("l4_resp_valid", 32'(resp_valid2), 32'(exp_rv2));
        check_eq("l4_issued_cnt", issued_cnt2, 32'(m_cnt2));

        @(posedge clk);
        if (rst) begin
            if (g >= 0) begin
                sb.push_back('{due: cyc + 2, idx: g, prod: op_a[g] * op_b[g]});
                m_ptr = (g + 1) % 4;
                m_cnt++;
            end
            if (m_armed) begin
                sb2.push_back('{due: cyc + 4, idx: 0, prod: a2 * b2});
                m_cnt2++;
            end
            m_armed = 1;
        end
        cyc++;
        #1;
        a2 = $urandom;
        b2 = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    initial begin
        cyc = 0; m_ptr = 0; m_cnt = 0; m_cnt2 = 0; m_armed = 0;
        rst = 1'b0; en = 1'b1; req_valid = '0;
        a2 = 32'd3; b2 = 32'd5;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (2) cycle();
        check_eq("rst_cnt", issued_cnt, 32'd0);

        // release cycle with a valid requester: must not be granted yet
        rst = 1'b1;
        req_valid = 4'b0100;
        cycle();
        op_a[2] = 32'd7;
        op_b[2] = 32'd6;
        cycle();
        req_valid = '0;
        repeat (3) cycle();
        check_eq("t1_cnt", issued_cnt, 32'd1);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 32'(i + 1);
            op_b[i] = 32'd10;
        end
        req_valid = 4'b1111;
        repeat (8) cycle();
        req_valid = '0;
        repeat (3) cycle();
        check_eq("t2_cnt", issued_cnt, 32'd8);

        do_reset();
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'b1010;
        repeat (2) cycle();
        req_valid = '0;
        repeat (3) cycle();

        do_reset();
        req_valid = 4'b1111;
        repeat (3) cycle();
        req_valid = '0;
        cycle();
        rst = 1'b0;
        cycle();
        check_eq("t4_cnt", issued_cnt, 32'd0);
        rst = 1'b1;
        req_valid = 4'b1111;
        repeat (4) cycle();
        req_valid = '0;
        repeat (3) cycle();

        do_reset();
        req_valid = 4'b0010;
        cycle();
        en = 1'b0;
        req_valid = 4'b1111;
        repeat (5) cycle();
        en = 1'b1;
        cycle();
        req_valid = '0;
        repeat (3) cycle();
        check_eq("t5_cnt", issued_cnt, 32'd2);

        for (int n = 0; n < 600; n++) begin
            en        = ($urandom_range(0, 7) != 0);
            req_valid = 4'($urandom);
            rst       = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < 4; i++) begin
                op_a[i] = $urandom;
                op_b[i] = $urandom;
            end
            cycle();
        end
        rst = 1'b1;
        req_valid = '0;
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
